// File: rtl/test_nios2_gen2_0_cpu_mult_combine_pkg.sv
// Shared constants for the Nios II MUL/MULX combine stage: op codes, FSM
// encoding, datapath widths and the hi*hi iteration count.
package test_nios2_gen2_0_cpu_mult_combine_pkg;

    localparam int DATA_W = 32;
    localparam int HALF_W = 16;
    localparam int ITER_N = 16;
    localparam int CNT_W  = 4;

    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(ITER_N - 1);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULXUU = 2'b01;
    localparam logic [1:0] OP_MULXSU = 2'b10;
    localparam logic [1:0] OP_MULXSS = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_HIMUL = 2'b01;
    localparam logic [1:0] ST_CORR  = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    function automatic logic op_is_mulx(input logic [1:0] op);
        return op != OP_MUL;
    endfunction

    function automatic logic src1_is_signed(input logic [1:0] op);
        return (op == OP_MULXSU) || (op == OP_MULXSS);
    endfunction

endpackage

// File: rtl/test_nios2_gen2_0_cpu_mult_combine_mult_seq16.sv
// 16x16 unsigned shift-add multiplier, one multiplier bit per clock.
// valid rises with the final product and holds until the next load.
module test_nios2_gen2_0_cpu_mult_seq16
    import test_nios2_gen2_0_cpu_mult_combine_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [HALF_W-1:0] a,
    input  logic [HALF_W-1:0] b,
    output logic [DATA_W-1:0] prod,
    output logic              valid
);

    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [HALF_W-2:0] mplier_q, mplier_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              run_q, run_d;
    logic              valid_q, valid_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        valid_d  = valid_q;
        if (load) begin
            // Bit 0 is folded into the load so that iterations 1..15 finish
            // in time for the caller to move on after 16 cycles.
            acc_d    = b[0] ? {{HALF_W{1'b0}}, a} : '0;
            mcand_d  = {{(HALF_W-1){1'b0}}, a, 1'b0};
            mplier_d = b[HALF_W-1:1];
            cnt_d    = CNT_W'(1);
            run_d    = 1'b1;
            valid_d  = 1'b0;
        end else if (run_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = {mcand_q[DATA_W-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[HALF_W-2:1]};
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == ITER_LAST) begin
                run_d   = 1'b0;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            valid_q  <= valid_d;
        end
    end

    assign prod  = acc_q;
    assign valid = valid_q;

endmodule

// File: rtl/test_nios2_gen2_0_cpu_mult_combine.sv
// Combines externally computed partial products into the MUL low word, or
// runs a sequential hi*hi plus sign correction for the MULX high word.
module test_nios2_gen2_0_cpu_mult_combine
    import test_nios2_gen2_0_cpu_mult_combine_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        M_en,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic [31:0] M_mul_cell_p1,
    input  logic [31:0] M_mul_cell_p2,
    input  logic [31:0] M_mul_cell_p3,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              done_q, done_d;
    logic [HALF_W:0]   mid_hi_q, mid_hi_d;
    logic              carry_q, carry_d;
    logic [DATA_W-1:0] src1_q, src1_d;
    logic [DATA_W-1:0] src2_q, src2_d;
    logic [1:0]        op_q, op_d;

    logic              accept;
    logic              seq_load;
    logic              seq_valid;
    logic [DATA_W-1:0] seq_prod;
    logic [DATA_W:0]   mid;
    logic [DATA_W:0]   low_sum;
    logic [DATA_W-1:0] uh;
    logic [DATA_W-1:0] hi_word;

    assign accept   = start && M_en && (state_q == ST_IDLE);
    assign seq_load = accept && op_is_mulx(op);

    test_nios2_gen2_0_cpu_mult_seq16 u_seq16 (
        .clk   (clk),
        .reset (reset),
        .load  (seq_load),
        .a     (src1[DATA_W-1:HALF_W]),
        .b     (src2[DATA_W-1:HALF_W]),
        .prod  (seq_prod),
        .valid (seq_valid)
    );

    always_comb begin
        mid     = {1'b0, M_mul_cell_p2} + {1'b0, M_mul_cell_p3};
        low_sum = {1'b0, M_mul_cell_p1} + {1'b0, mid[HALF_W-1:0], {HALF_W{1'b0}}};
    end

    // Unsigned high word, then two's-complement correction for signed operands.
    always_comb begin
        uh = seq_prod
           + {{(DATA_W-HALF_W-1){1'b0}}, mid_hi_q}
           + {{(DATA_W-1){1'b0}}, carry_q};
        hi_word = uh;
        if (src1_is_signed(op_q) && src1_q[DATA_W-1]) begin
            hi_word = hi_word - src2_q;
        end
        if ((op_q == OP_MULXSS) && src2_q[DATA_W-1]) begin
            hi_word = hi_word - src1_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        done_d   = 1'b0;
        mid_hi_d = mid_hi_q;
        carry_d  = carry_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        op_d     = op_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (op_is_mulx(op)) begin
                        state_d  = ST_HIMUL;
                        mid_hi_d = mid[DATA_W:HALF_W];
                        carry_d  = low_sum[DATA_W];
                        src1_d   = src1;
                        src2_d   = src2;
                        op_d     = op;
                    end else begin
                        result_d = low_sum[DATA_W-1:0];
                        done_d   = 1'b1;
                    end
                end
            end
            ST_HIMUL: begin
                if (seq_valid) begin
                    state_d = ST_CORR;
                end
            end
            ST_CORR: begin
                result_d = hi_word;
                done_d   = 1'b1;
                state_d  = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            done_q   <= 1'b0;
            mid_hi_q <= '0;
            carry_q  <= 1'b0;
            src1_q   <= '0;
            src2_q   <= '0;
            op_q     <= OP_MUL;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            done_q   <= done_d;
            mid_hi_q <= mid_hi_d;
            carry_q  <= carry_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            op_q     <= op_d;
        end
    end

    assign busy   = (state_q == ST_HIMUL) || (state_q == ST_CORR);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_test_nios2_gen2_0_cpu_mult_combine.sv
// Scoreboard bench: the driver queues expected results from a 64-bit
// arithmetic model; a monitor pops and compares on every done pulse.
module tb_test_nios2_gen2_0_cpu_mult_combine;

    localparam logic [1:0] T_MUL = 2'b00;
    localparam logic [1:0] T_UU  = 2'b01;
    localparam logic [1:0] T_SU  = 2'b10;
    localparam logic [1:0] T_SS  = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        M_en;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src1, src2, p1, p2, p3;
    logic        busy, done;
    logic [31:0] result;

    test_nios2_gen2_0_cpu_mult_combine dut (
        .clk           (clk),
        .reset         (reset),
        .M_en          (M_en),
        .start         (start),
        .op            (op),
        .src1          (src1),
        .src2          (src2),
        .M_mul_cell_p1 (p1),
        .M_mul_cell_p2 (p2),
        .M_mul_cell_p3 (p3),
        .busy          (busy),
        .done          (done),
        .result        (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          due;
        string       name;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_res = '0;

    function automatic logic [31:0] ref_result(input logic [1:0] o,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [65:0] sa, sb, pr;
        sa = (o == T_SU || o == T_SS) ? {{34{a[31]}}, a} : {34'b0, a};
        sb = (o == T_SS) ? {{34{b[31]}}, b} : {34'b0, b};
        pr = sa * sb;
        return (o == T_MUL) ? pr[31:0] : pr[63:32];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no completion", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check({e.name, "_result"}, result, e.res);
                check({e.name, "_cycle"}, 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic set_operands(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] lo1, lo2, hi1, hi2;
        lo1 = {16'h0, a[15:0]};
        hi1 = {16'h0, a[31:16]};
        lo2 = {16'h0, b[15:0]};
        hi2 = {16'h0, b[31:16]};
        op   = o;
        src1 = a;
        src2 = b;
        p1   = lo1 * lo2;
        p2   = lo1 * hi2;
        p3   = hi1 * lo2;
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that samples start.
    task automatic issue(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic en, input logic push);
        exp_t e;
        set_operands(o, a, b);
        M_en  = en;
        start = 1'b1;
        if (push) begin
            e.res  = ref_result(o, a, b);
            e.due  = cyc + ((o == T_MUL) ? 1 : 18);
            e.name = name;
            q.push_back(e);
            last_res = e.res;
        end
        @(posedge clk); #1;
        start = 1'b0;
        M_en  = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (q.size() != 0 && n < 40);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
        check("result_hold", result, last_res);
    endtask

    initial begin
        logic [1:0]  ro;
        logic        ren;
        logic [31:0] ra, rb;

        reset = 1'b1; M_en = 1'b0; start = 1'b0;
        set_operands(T_MUL, '0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_result", result, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        issue("mul_dir", T_MUL, 32'h0001_0003, 32'h0002_0005, 1'b1, 1'b1);
        @(negedge clk);
        check("mul_busy", {31'b0, busy}, 32'h0);
        drain();
        check("mul_const", result, 32'h000B_000F);

        issue("mulxuu_dir", T_UU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            check($sformatf("uu_busy_c%0d", i), {31'b0, busy}, 32'h1);
        end
        @(negedge clk);
        check("uu_busy_c18", {31'b0, busy}, 32'h0);
        drain();
        check("mulxuu_const", result, 32'hFFFF_FFFE);

        issue("mulxsu_dir", T_SU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        drain();
        check("mulxsu_const", result, 32'hFFFF_FFFF);
        issue("mulxss_dir", T_SS, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b1);
        drain();
        check("mulxss_const", result, 32'hFFFF_FFFF);

        issue("men0", T_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check("men0_hold", result, last_res);

        issue("mulx_busy_start", T_SS, $urandom, $urandom, 1'b1, 1'b1);
        repeat (4) begin @(posedge clk); #1; end
        set_operands(T_MUL, 32'h0000_0007, 32'h0000_0009);
        M_en = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        drain();

        issue("mulx_before_done", T_UU, $urandom, $urandom, 1'b1, 1'b1);
        repeat (17) begin @(posedge clk); #1; end
        check("done_cycle_pulse", {31'b0, done}, 32'h1);
        set_operands(T_MUL, 32'h0000_0003, 32'h0000_0003);
        M_en = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        issue("mul_after_done", T_MUL, 32'h0001_0002, 32'h0003_0004, 1'b1, 1'b1);
        drain();

        issue("mulx_abort", T_UU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        repeat (7) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        check("abort_result", result, 32'h0);
        check("abort_busy", {31'b0, busy}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        last_res = '0;
        repeat (20) @(posedge clk);
        #1;
        check("abort_hold", result, 32'h0);
        issue("mul_post_reset", T_MUL, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b1);
        drain();

        for (int n = 0; n < 40; n++) begin
            ro  = 2'($urandom_range(0, 3));
            ra  = pick();
            rb  = pick();
            ren = ($urandom_range(0, 4) != 0);
            issue($sformatf("rnd%0d_op%0d", n, ro), ro, ra, rb, ren, ren);
            drain();
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        check("queue_empty", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
